// File: rtl/bolme_denetleyici_if.sv
// ---------------------------------------------------------------------------
// bolme_denetleyici_if
// Bundles the controller's three buses: the upstream request/stall signals,
// the downstream result handshake, and the iterative-divider handshake.
//   Upstream  : gecerli_i, islem_i, bolunen_i, bolen_i, hedef_i, temizle_i,
//               hazir_o, durdur_o
//   Downstream: sonuc_gecerli_o, sonuc_o, hedef_o, sonuc_hazir_i
//   Divider   : bb_basla_o, bb_islem_o, bb_bolunen_o, bb_bolen_o,
//               bb_sonuc_i, bb_bitti_i
//   Status    : hata_o (one-cycle timeout pulse)
// Modports: slave = the controller itself, master = its environment.
// ---------------------------------------------------------------------------
interface bolme_denetleyici_if;
    logic        gecerli_i;
    logic [1:0]  islem_i;
    logic [31:0] bolunen_i;
    logic [31:0] bolen_i;
    logic [4:0]  hedef_i;
    logic        hazir_o;
    logic        temizle_i;
    logic        durdur_o;
    logic        sonuc_gecerli_o;
    logic [31:0] sonuc_o;
    logic [4:0]  hedef_o;
    logic        sonuc_hazir_i;
    logic        bb_basla_o;
    logic [1:0]  bb_islem_o;
    logic [31:0] bb_bolunen_o;
    logic [31:0] bb_bolen_o;
    logic [31:0] bb_sonuc_i;
    logic        bb_bitti_i;
    logic        hata_o;

    modport slave (
        input  gecerli_i, islem_i, bolunen_i, bolen_i, hedef_i, temizle_i,
               sonuc_hazir_i, bb_sonuc_i, bb_bitti_i,
        output hazir_o, durdur_o, sonuc_gecerli_o, sonuc_o, hedef_o,
               bb_basla_o, bb_islem_o, bb_bolunen_o, bb_bolen_o, hata_o
    );

    modport master (
        output gecerli_i, islem_i, bolunen_i, bolen_i, hedef_i, temizle_i,
               sonuc_hazir_i, bb_sonuc_i, bb_bitti_i,
        input  hazir_o, durdur_o, sonuc_gecerli_o, sonuc_o, hedef_o,
               bb_basla_o, bb_islem_o, bb_bolunen_o, bb_bolen_o, hata_o
    );
endinterface

// File: rtl/bolme_denetleyici.sv
// ---------------------------------------------------------------------------
// bolme_denetleyici
// Sequencing controller between a CPU pipeline and an iterative divider.
// Accepts one DIVU/REMU/DIV/REM request at a time, handles divide-by-zero
// without the divider, watches the divider with a timeout, and holds the
// result until writeback takes it.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : bolme_denetleyici_if.slave (request, result, divider, hata_o)
//   ZAMAN_ASIMI : max BOLUYOR cycles before the operation is abandoned
// Optional feature: define BOLME_ONBELLEK_EN for a single-entry result cache
// keyed on {islem, bolunen, bolen}.
// ---------------------------------------------------------------------------
module bolme_denetleyici #(
    parameter int ZAMAN_ASIMI = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    bolme_denetleyici_if.slave    bus
);
    localparam int SW = $clog2(ZAMAN_ASIMI + 1);

    typedef enum logic [1:0] {BOS, BOLUYOR, SONUC} durum_t;

    durum_t        r_durum, w_sonraki;
    logic [1:0]    r_islem;
    logic [31:0]   r_bolunen, r_bolen, r_sonuc;
    logic [4:0]    r_hedef;
    logic [SW-1:0] r_sayac;
    logic          r_hata;

    logic          w_kabul, w_sifir, w_asim, w_isabet;
    logic [31:0]   w_sifir_sonuc, w_ob_sonuc;

    // A flush in the same cycle blocks acceptance.
    assign w_kabul       = bus.gecerli_i && (r_durum == BOS) && !bus.temizle_i;
    assign w_sifir       = (bus.bolen_i == 32'd0);
    // islem[0] selects remainder: x/0 = all ones, x%0 = x.
    assign w_sifir_sonuc = bus.islem_i[0] ? bus.bolunen_i : 32'hFFFF_FFFF;
    // Completion in the final allowed cycle still wins over the timeout.
    assign w_asim        = (r_durum == BOLUYOR) && !bus.bb_bitti_i &&
                           (r_sayac == SW'(ZAMAN_ASIMI));

`ifdef BOLME_ONBELLEK_EN
    logic          r_ob_gecerli;
    logic [1:0]    r_ob_islem;
    logic [31:0]   r_ob_bolunen, r_ob_bolen, r_ob_sonuc;

    assign w_isabet   = r_ob_gecerli && (r_ob_islem == bus.islem_i) &&
                        (r_ob_bolunen == bus.bolunen_i) && (r_ob_bolen == bus.bolen_i);
    assign w_ob_sonuc = r_ob_sonuc;

    // Entry written at handoff, so flushed or timed-out work never lands here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ob_gecerli <= 1'b0;
            r_ob_islem   <= '0;
            r_ob_bolunen <= '0;
            r_ob_bolen   <= '0;
            r_ob_sonuc   <= '0;
        end else if ((r_durum == SONUC) && bus.sonuc_hazir_i && !bus.temizle_i) begin
            r_ob_gecerli <= 1'b1;
            r_ob_islem   <= r_islem;
            r_ob_bolunen <= r_bolunen;
            r_ob_bolen   <= r_bolen;
            r_ob_sonuc   <= r_sonuc;
        end
    end
`else
    assign w_isabet   = 1'b0;
    assign w_ob_sonuc = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) r_durum <= BOS;
        else       r_durum <= w_sonraki;
    end

    always_comb begin
        w_sonraki = r_durum;
        if (bus.temizle_i) begin
            w_sonraki = BOS;
        end else begin
            case (r_durum)
                BOS:     if (w_kabul) w_sonraki = (w_sifir || w_isabet) ? SONUC : BOLUYOR;
                BOLUYOR: if (bus.bb_bitti_i) w_sonraki = SONUC;
                         else if (w_asim)   w_sonraki = BOS;
                SONUC:   if (bus.sonuc_hazir_i) w_sonraki = BOS;
                default: w_sonraki = BOS;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_islem   <= '0;
            r_bolunen <= '0;
            r_bolen   <= '0;
            r_hedef   <= '0;
            r_sonuc   <= '0;
            r_sayac   <= '0;
            r_hata    <= 1'b0;
        end else begin
            r_hata <= w_asim && !bus.temizle_i;
            // Counter reads 1 in the first BOLUYOR cycle, 0 everywhere else.
            if (w_sonraki == BOLUYOR)
                r_sayac <= (r_durum == BOLUYOR) ? r_sayac + 1'b1 : SW'(1);
            else
                r_sayac <= '0;
            if (w_kabul) begin
                r_islem   <= bus.islem_i;
                r_bolunen <= bus.bolunen_i;
                r_bolen   <= bus.bolen_i;
                r_hedef   <= bus.hedef_i;
                // Preloaded for bypass/hit; the divider path overwrites it.
                r_sonuc   <= w_sifir ? w_sifir_sonuc : w_ob_sonuc;
            end else if ((r_durum == BOLUYOR) && bus.bb_bitti_i) begin
                r_sonuc   <= bus.bb_sonuc_i;
            end
        end
    end

    assign bus.hazir_o         = (r_durum == BOS);
    assign bus.durdur_o        = (r_durum != BOS) || (bus.gecerli_i && !bus.hazir_o);
    assign bus.bb_basla_o      = (r_durum == BOLUYOR);
    // Operand registers only change on acceptance, so they hold through BOLUYOR.
    assign bus.bb_islem_o      = r_islem;
    assign bus.bb_bolunen_o    = r_bolunen;
    assign bus.bb_bolen_o      = r_bolen;
    assign bus.sonuc_gecerli_o = (r_durum == SONUC);
    assign bus.sonuc_o         = (r_durum == SONUC) ? r_sonuc : 32'd0;
    assign bus.hedef_o         = (r_durum == SONUC) ? r_hedef : 5'd0;
    assign bus.hata_o          = r_hata;
endmodule

// File: tb/tb_bolme_denetleyici.sv
module tb_bolme_denetleyici;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bolme_denetleyici_if bus();

    bolme_denetleyici #(.ZAMAN_ASIMI(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Divider model: raises bb_bitti_i in the 18th cycle of bb_basla_o.
    logic [31:0] tb_bb_sonuc = '0;
    logic        tb_bitti_kapali = 1'b0;
    int          bb_say = 0;
    always @(posedge clk) bb_say <= bus.bb_basla_o ? bb_say + 1 : 0;
    assign bus.bb_bitti_i = bus.bb_basla_o && (bb_say == 17) && !tb_bitti_kapali;
    assign bus.bb_sonuc_i = tb_bb_sonuc;

    task automatic adim();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for one cycle; returns in cycle t+1.
    task automatic istek(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] h);
        bus.gecerli_i = 1'b1;
        bus.islem_i   = op;
        bus.bolunen_i = a;
        bus.bolen_i   = b;
        bus.hedef_i   = h;
        adim();
        bus.gecerli_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] f;
        int bad;
        rst = 1'b1;
        adim(); adim();
        rst = 1'b0;
        f = {bus.hazir_o, bus.durdur_o, bus.bb_basla_o, bus.sonuc_gecerli_o, bus.hata_o};
        checks++;
        if (f !== 5'b10000) begin
            errors++; $display("FAIL reset_flags got %b exp 10000", f);
        end
        checks++;
        if ({bus.bb_islem_o, bus.bb_bolunen_o, bus.bb_bolen_o, bus.sonuc_o, bus.hedef_o} !== '0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h/%h/%h exp 0", bus.bb_islem_o,
                               bus.bb_bolunen_o, bus.bb_bolen_o, bus.sonuc_o, bus.hedef_o);
        end
        // Reset in the middle of a divide: abort, no result, no error pulse.
        tb_bb_sonuc = 32'd3;
        istek(2'b00, 32'd9, 32'd3, 5'd2);
        repeat (4) adim();
        rst = 1'b1; adim(); rst = 1'b0;
        checks++;
        if (bus.hazir_o !== 1'b1 || bus.bb_basla_o !== 1'b0 || bus.bb_bolunen_o !== 32'd0) begin
            errors++; $display("FAIL midop_reset got hazir=%b basla=%b bolunen=%h exp 1 0 0",
                               bus.hazir_o, bus.bb_basla_o, bus.bb_bolunen_o);
        end
        bad = 0;
        for (int k = 0; k < 35; k++) begin
            if (bus.hata_o !== 1'b0 || bus.sonuc_gecerli_o !== 1'b0) bad++;
            adim();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL midop_reset_quiet got %0d bad cycles exp 0", bad);
        end
    endtask

    // Normal divider operation with sonuc_hazir_i held high.
    task automatic test_islem(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] h, input logic [31:0] res);
        int bad;
        tb_bb_sonuc       = res;
        bus.sonuc_hazir_i = 1'b1;
        istek(op, a, b, h);
        bad = 0;
        for (int k = 1; k <= 18; k++) begin
            if (bus.bb_basla_o !== 1'b1 || bus.hazir_o !== 1'b0 || bus.durdur_o !== 1'b1 ||
                bus.bb_islem_o !== op || bus.bb_bolunen_o !== a || bus.bb_bolen_o !== b ||
                bus.sonuc_gecerli_o !== 1'b0) bad++;
            adim();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL islem_busy op=%0d got %0d bad cycles exp 0", op, bad);
        end
        checks++;
        if (bus.sonuc_gecerli_o !== 1'b1 || bus.sonuc_o !== res || bus.hedef_o !== h ||
            bus.bb_basla_o !== 1'b0) begin
            errors++; $display("FAIL islem_result op=%0d got v=%b s=%h h=%0d b=%b exp 1 %h %0d 0",
                               op, bus.sonuc_gecerli_o, bus.sonuc_o, bus.hedef_o, bus.bb_basla_o, res, h);
        end
        adim();
        checks++;
        if (bus.hazir_o !== 1'b1 || bus.sonuc_gecerli_o !== 1'b0 || bus.sonuc_o !== 32'd0 ||
            bus.hedef_o !== 5'd0) begin
            errors++; $display("FAIL islem_idle op=%0d got hazir=%b v=%b s=%h h=%0d exp 1 0 0 0",
                               op, bus.hazir_o, bus.sonuc_gecerli_o, bus.sonuc_o, bus.hedef_o);
        end
    endtask

    task automatic test_sifir();
        logic [1:0]  ops [2];
        logic [31:0] exps[2];
        ops[0] = 2'b10; exps[0] = 32'hFFFF_FFFF;
        ops[1] = 2'b01; exps[1] = 32'd5;
        bus.sonuc_hazir_i = 1'b1;
        tb_bb_sonuc       = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            istek(ops[i], 32'd5, 32'd0, 5'd11);
            checks++;
            if (bus.sonuc_gecerli_o !== 1'b1 || bus.sonuc_o !== exps[i] || bus.hedef_o !== 5'd11 ||
                bus.bb_basla_o !== 1'b0) begin
                errors++; $display("FAIL sifir_result op=%0d got v=%b s=%h h=%0d b=%b exp 1 %h 11 0",
                                   ops[i], bus.sonuc_gecerli_o, bus.sonuc_o, bus.hedef_o,
                                   bus.bb_basla_o, exps[i]);
            end
            adim();
            checks++;
            if (bus.hazir_o !== 1'b1 || bus.bb_basla_o !== 1'b0) begin
                errors++; $display("FAIL sifir_idle op=%0d got hazir=%b basla=%b exp 1 0",
                                   ops[i], bus.hazir_o, bus.bb_basla_o);
            end
        end
    endtask

    task automatic test_bekle();
        tb_bb_sonuc       = 32'd100;
        bus.sonuc_hazir_i = 1'b0;
        istek(2'b00, 32'd1000, 32'd10, 5'd9);
        repeat (18) adim();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.sonuc_gecerli_o !== 1'b1 || bus.sonuc_o !== 32'd100 || bus.hedef_o !== 5'd9 ||
                bus.hazir_o !== 1'b0 || bus.durdur_o !== 1'b1) begin
                errors++; $display("FAIL bekle_hold k=%0d got v=%b s=%h h=%0d hz=%b d=%b exp 1 64 9 0 1",
                                   k, bus.sonuc_gecerli_o, bus.sonuc_o, bus.hedef_o, bus.hazir_o,
                                   bus.durdur_o);
            end
            adim();
        end
        // Handoff cycle with a new request waiting: it must not be taken.
        bus.sonuc_hazir_i = 1'b1;
        bus.gecerli_i = 1'b1; bus.islem_i = 2'b00; bus.bolunen_i = 32'd8; bus.bolen_i = 32'd2;
        adim();
        bus.gecerli_i = 1'b0;
        checks++;
        if (bus.hazir_o !== 1'b1 || bus.bb_basla_o !== 1'b0 || bus.sonuc_gecerli_o !== 1'b0 ||
            bus.durdur_o !== 1'b0) begin
            errors++; $display("FAIL bekle_handoff got hz=%b b=%b v=%b d=%b exp 1 0 0 0",
                               bus.hazir_o, bus.bb_basla_o, bus.sonuc_gecerli_o, bus.durdur_o);
        end
    endtask

    task automatic test_temizle();
        int bad;
        tb_bb_sonuc       = 32'd22;
        bus.sonuc_hazir_i = 1'b1;
        istek(2'b00, 32'd200, 32'd9, 5'd4);
        repeat (9) adim();
        bus.temizle_i = 1'b1;
        adim();
        bus.temizle_i = 1'b0;
        checks++;
        if (bus.bb_basla_o !== 1'b0 || bus.hazir_o !== 1'b1) begin
            errors++; $display("FAIL temizle_stop got basla=%b hazir=%b exp 0 1",
                               bus.bb_basla_o, bus.hazir_o);
        end
        bad = 0;
        for (int k = 0; k < 25; k++) begin
            if (bus.sonuc_gecerli_o !== 1'b0) bad++;
            adim();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL temizle_noresult got %0d valid cycles exp 0", bad);
        end
        test_islem(2'b00, 32'd50, 32'd5, 5'd3, 32'd10);
    endtask

    task automatic test_temizle_kabul();
        bus.temizle_i = 1'b1;
        bus.gecerli_i = 1'b1; bus.islem_i = 2'b00; bus.bolunen_i = 32'd8; bus.bolen_i = 32'd2;
        adim();
        bus.temizle_i = 1'b0;
        bus.gecerli_i = 1'b0;
        checks++;
        if (bus.hazir_o !== 1'b1 || bus.bb_basla_o !== 1'b0 || bus.sonuc_gecerli_o !== 1'b0) begin
            errors++; $display("FAIL temizle_kabul got hz=%b b=%b v=%b exp 1 0 0",
                               bus.hazir_o, bus.bb_basla_o, bus.sonuc_gecerli_o);
        end
    endtask

    task automatic test_onbellek();
        test_islem(2'b00, 32'd100, 32'd7, 5'd6, 32'd14);
`ifdef BOLME_ONBELLEK_EN
        tb_bb_sonuc = 32'd0;
        istek(2'b00, 32'd100, 32'd7, 5'd7);
        checks++;
        if (bus.sonuc_gecerli_o !== 1'b1 || bus.sonuc_o !== 32'd14 || bus.hedef_o !== 5'd7 ||
            bus.bb_basla_o !== 1'b0) begin
            errors++; $display("FAIL onbellek_hit got v=%b s=%h h=%0d b=%b exp 1 e 7 0",
                               bus.sonuc_gecerli_o, bus.sonuc_o, bus.hedef_o, bus.bb_basla_o);
        end
        adim();
        checks++;
        if (bus.hazir_o !== 1'b1 || bus.bb_basla_o !== 1'b0) begin
            errors++; $display("FAIL onbellek_idle got hz=%b b=%b exp 1 0", bus.hazir_o, bus.bb_basla_o);
        end
`else
        test_islem(2'b00, 32'd100, 32'd7, 5'd7, 32'd14);
`endif
    endtask

    task automatic test_zaman_asimi();
        int bad;
        tb_bitti_kapali   = 1'b1;
        bus.sonuc_hazir_i = 1'b1;
        istek(2'b00, 32'd9, 32'd3, 5'd1);
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            if (bus.hata_o !== 1'b0 || bus.bb_basla_o !== 1'b1) bad++;
            adim();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL asim_wait got %0d bad cycles exp 0", bad);
        end
        checks++;
        if (bus.hata_o !== 1'b1 || bus.hazir_o !== 1'b1 || bus.bb_basla_o !== 1'b0 ||
            bus.sonuc_gecerli_o !== 1'b0) begin
            errors++; $display("FAIL asim_pulse got hata=%b hz=%b b=%b v=%b exp 1 1 0 0",
                               bus.hata_o, bus.hazir_o, bus.bb_basla_o, bus.sonuc_gecerli_o);
        end
        adim();
        checks++;
        if (bus.hata_o !== 1'b0 || bus.sonuc_gecerli_o !== 1'b0) begin
            errors++; $display("FAIL asim_after got hata=%b v=%b exp 0 0", bus.hata_o, bus.sonuc_gecerli_o);
        end
        tb_bitti_kapali = 1'b0;
    endtask

    initial begin
        bus.gecerli_i = 1'b0; bus.islem_i = '0; bus.bolunen_i = '0; bus.bolen_i = '0;
        bus.hedef_i = '0; bus.temizle_i = 1'b0; bus.sonuc_hazir_i = 1'b0;
        test_reset();
        test_islem(2'b00, 32'd100, 32'd7, 5'd5, 32'd14);
        test_islem(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFF);
        test_islem(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000);
        test_sifir();
        test_bekle();
        test_temizle();
        test_temizle_kabul();
        test_onbellek();
        test_zaman_asimi();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bolme_denetleyici.md
BOLME_DENETLEYICI -- requirements
Module: bolme_denetleyici

Interface
REQ-001 The block SHALL have parameter ZAMAN_ASIMI, default 32, giving the maximum number of cycles it waits for divider completion before aborting.
REQ-002 The block SHALL have clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have rst_i, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have the following upstream request ports: gecerli_i (input, 1, request valid), islem_i (input, 2: 00 DIVU, 01 REMU, 10 DIV, 11 REM), bolunen_i (input, 32), bolen_i (input, 32) and hedef_i (input, 5, destination register tag).
REQ-005 The block SHALL have hazir_o, output, 1; the block accepts a request in any cycle where gecerli_i and hazir_o are both high.
REQ-006 The block SHALL have temizle_i, input, 1, a pipeline flush.
REQ-007 The block SHALL have durdur_o, output, 1, a stall to the upstream pipeline.
REQ-008 The block SHALL have the following downstream result ports: sonuc_gecerli_o (output, 1), sonuc_o (output, 32), hedef_o (output, 5) and sonuc_hazir_i (input, 1, writeback accepts the result).
REQ-009 The block SHALL have the following divider-side ports: bb_basla_o (output, 1), bb_islem_o (output, 2), bb_bolunen_o (output, 32), bb_bolen_o (output, 32), bb_sonuc_i (input, 32) and bb_bitti_i (input, 1).
REQ-010 The block SHALL have hata_o, output, 1, a one-cycle timeout pulse.

Function
REQ-011 The block SHALL implement three states: BOS, BOLUYOR and SONUC.
REQ-012 hazir_o SHALL be 1 only in BOS.
REQ-013 durdur_o SHALL be 1 when in BOLUYOR or SONUC, or when gecerli_i is high and hazir_o is low.
REQ-014 On acceptance, the block SHALL register islem_i, bolunen_i, bolen_i and hedef_i.
REQ-015 Operands SHALL remain stable on bb_* outputs until the operation leaves BOLUYOR.
REQ-016 When an accepted request has bolen_i==0, the block SHALL bypass the divider, go directly to SONUC next cycle, and produce a result of 0xFFFFFFFF for DIVU/DIV or bolunen_i for REMU/REM.
REQ-017 For any other accepted request, the block SHALL go to BOLUYOR next cycle.
REQ-018 bb_basla_o SHALL be 1 exactly while in BOLUYOR and SHALL not drop until completion, timeout or flush.
REQ-019 In BOLUYOR, a cycle counter SHALL start at 1 on entry and increment each cycle.
REQ-020 In BOLUYOR, on bb_bitti_i==1, the block SHALL capture bb_sonuc_i into the result register and go to SONUC.
REQ-021 Nominal timing SHALL be: accept at cycle t; bb_basla_o high t+1..t+18; bb_bitti_i high at t+18; sonuc_gecerli_o high from t+19.
REQ-022 If the counter reaches ZAMAN_ASIMI without bb_bitti_i, the block SHALL pulse hata_o for 1 cycle, go to BOS and produce no result.
REQ-023 bb_basla_o SHALL always be low for at least 1 cycle between two divider operations; SONUC guarantees this gap.
REQ-024 In SONUC, sonuc_gecerli_o SHALL be 1, and sonuc_o and hedef_o SHALL be held stable until sonuc_hazir_i==1.
REQ-025 In SONUC, in the cycle sonuc_hazir_i==1, the block SHALL go to BOS next cycle.
REQ-026 The block SHALL never accept a new request in the same cycle a result is handed off.
REQ-027 temizle_i SHALL have priority over all other inputs in every state.
REQ-028 When temizle_i is high, the next state SHALL be BOS, bb_basla_o SHALL be 0 next cycle and sonuc_gecerli_o SHALL be 0 next cycle.
REQ-029 A request presented with temizle_i high SHALL not be accepted.
REQ-030 Outside SONUC, sonuc_o and hedef_o SHALL be 0.

Reset
REQ-031 On rst_i, the block SHALL enter BOS.
REQ-032 On rst_i, the outputs SHALL take these values: hazir_o=1, durdur_o=0 (unless gecerli_i), bb_basla_o=0, bb_islem_o=0, bb_bolunen_o=0, bb_bolen_o=0, sonuc_gecerli_o=0, sonuc_o=0, hedef_o=0 and hata_o=0.
REQ-033 On rst_i, the counter and all operand registers SHALL be cleared.
REQ-034 On rst_i, the cache SHALL be invalidated.
REQ-035 rst_i asserted mid-operation SHALL abort the operation with no result and no hata_o pulse.

Configuration
REQ-036 Macro BOLME_ONBELLEK_EN SHALL control a single-entry result cache.
REQ-037 With BOLME_ONBELLEK_EN defined, the block SHALL store {islem, bolunen, bolen, result} of every operation completed via the divider or the zero bypass.
REQ-038 With BOLME_ONBELLEK_EN defined, an accepted request matching all three stored fields with the cache valid SHALL go directly to SONUC next cycle with the cached result, and the divider SHALL not be started.
REQ-039 With BOLME_ONBELLEK_EN defined, flushed or timed-out operations SHALL not update the cache.
REQ-040 Without BOLME_ONBELLEK_EN, no cache storage SHALL exist and every non-zero-divisor request SHALL use the divider.

Verification
REQ-041 The bench SHALL cover this scenario: DIVU 100/7 accepted at t, sonuc_hazir_i=1 -> bb_basla_o high t+1..t+18, sonuc_gecerli_o at t+19, sonuc_o=14, hedef_o preserved.
REQ-042 The bench SHALL cover this scenario: REM -7/2 -> sonuc_o=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> sonuc_o=0x80000000.
REQ-043 The bench SHALL cover this scenario: DIV 5/0 -> sonuc_gecerli_o at t+1, sonuc_o=0xFFFFFFFF, bb_basla_o never high; REMU 5/0 -> sonuc_o=5.
REQ-044 The bench SHALL cover this scenario: sonuc_hazir_i held low 5 cycles in SONUC -> sonuc_o stable, hazir_o=0, durdur_o=1 throughout; then BOS 1 cycle after handshake.
REQ-045 The bench SHALL cover this scenario: temizle_i at t+10 of a DIVU -> bb_basla_o=0 at t+11, no sonuc_gecerli_o, next request accepted normally with correct result.
REQ-046 The bench SHALL cover this scenario: with BOLME_ONBELLEK_EN, DIVU 100/7 issued twice back-to-back -> second result 14 at accept+1 with no bb_basla_o; bb_bitti_i tied 0 -> hata_o pulse at counter=ZAMAN_ASIMI, state BOS.
